universal_nreg: RTL

UNIVERSAL_NREG -- requirements
Module: universal_nreg

---
 rtl/universal_nreg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/universal_nreg.sv
// N-bit universal shift register with multi-cycle shift-by-amt sequencer.
// Optional rotate support is enabled by defining UNIVERSAL_NREG_ROTATE_EN.
module universal_nreg #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  I,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic [AW-1:0] amt,
  input  logic          sin,
`ifdef UNIVERSAL_NREG_ROTATE_EN
  input  logic          rot,
`endif
  output logic [N-1:0]  Q,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic          dir_left_q, dir_left_d;
  logic          rot_q, rot_d;
  logic [N-1:0]  q_q, q_d;
  logic          sout_q, sout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          in_bit;
  logic          cmd_rot;

`ifdef UNIVERSAL_NREG_ROTATE_EN
  assign cmd_rot = rot;
`else
  assign cmd_rot = 1'b0;
`endif

  // Rotate feeds back the bit leaving the register instead of sin.
  always_comb begin
    in_bit = sin;
    if (rot_q) begin
      in_bit = dir_left_q ? q_q[N-1] : q_q[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_left_d  = dir_left_q;
    rot_d       = rot_q;
    q_d         = q_q;
    sout_d      = sout_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (mode)
            2'b00: ;
            2'b11: begin
              q_d    = I;
              done_d = 1'b1;
            end
            default: begin
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                dir_left_d  = (mode == 2'b10);
                rot_d       = cmd_rot;
                remaining_d = amt;
                busy_d      = 1'b1;
                state_d     = StShift;
              end
            end
          endcase
        end
      end
      StShift: begin
        if (dir_left_q) begin
          q_d    = {q_q[N-2:0], in_bit};
          sout_d = q_q[N-1];
        end else begin
          q_d    = {in_bit, q_q[N-1:1]};
          sout_d = q_q[0];
        end
        remaining_d = remaining_q - AW'(1);
        if (remaining_q == AW'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      dir_left_q  <= 1'b0;
      rot_q       <= 1'b0;
      q_q         <= '0;
      sout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_left_q  <= dir_left_d;
      rot_q       <= rot_d;
      q_q         <= q_d;
      sout_q      <= sout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
